// File: rtl/exec_flag_unit.sv
// exec_flag_unit: execute-stage ALU producing the N/Z flag stream for branch
// logic. Single-cycle add/sub/cmp and a multi-cycle unsigned shift-add
// multiply, with a start/busy/done handshake toward the control unit.
// Optional build macro EXEC_FLAG_OVF_EN adds C_out/V_out carry and overflow
// flags; the multiply accumulator then widens to 2*DATA_W bits.
module exec_flag_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              set_flags,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              N_in,
    output logic              Z_in,
    output logic              WE_flags,
    output logic              WE_result,
    output logic              busy,
    output logic              done
`ifdef EXEC_FLAG_OVF_EN
    ,
    output logic              C_out,
    output logic              V_out
`endif
);

`ifdef EXEC_FLAG_OVF_EN
    localparam int ACC_W = 2 * DATA_W;
`else
    localparam int ACC_W = DATA_W;
`endif
    localparam int MSB = DATA_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_CMP = 2'b11} op_t;

    state_t            state;
    op_t               op_in;
    logic              set_flags_q;
    logic [ACC_W-1:0]  a_sh;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] b_sh;
    logic [CNT_W-1:0]  cnt;

    logic [ACC_W-1:0]  acc_nxt;
    logic              last_iter;
    logic [DATA_W-1:0] alu_res;
    logic              fin_fire;
    logic [DATA_W-1:0] fin_res;
    logic              fin_we_res;
    logic              fin_sf;
`ifdef EXEC_FLAG_OVF_EN
    logic [DATA_W:0]   add_ext;
    logic [DATA_W:0]   sub_ext;
    logic              alu_c;
    logic              alu_v;
    logic              fin_c;
    logic              fin_v;
`endif

    assign op_in     = op_t'(op);
    assign acc_nxt   = acc + (b_sh[0] ? a_sh : '0);
    assign last_iter = (cnt == CNT_W'(DATA_W - 1));

    // Single-cycle ALU on the live operands; its value is registered at accept.
    always_comb begin
        alu_res = '0;
`ifdef EXEC_FLAG_OVF_EN
        add_ext = {1'b0, a} + {1'b0, b};
        sub_ext = {1'b0, a} + {1'b0, ~b} + (DATA_W + 1)'(1);
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_in)
            OP_ADD: begin
                alu_res = add_ext[DATA_W-1:0];
                alu_c   = add_ext[DATA_W];
                alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_ext[DATA_W-1:0];
                alu_c   = sub_ext[DATA_W];
                alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            default: alu_res = '0;
        endcase
`else
        case (op_in)
            OP_ADD:         alu_res = a + b;
            OP_SUB, OP_CMP: alu_res = a - b;
            default:        alu_res = '0;
        endcase
`endif
    end

    // Select what gets registered on entry to DONE: fast path or last multiply step.
    always_comb begin
        fin_fire   = 1'b0;
        fin_res    = '0;
        fin_we_res = 1'b0;
        fin_sf     = 1'b0;
`ifdef EXEC_FLAG_OVF_EN
        fin_c      = 1'b0;
        fin_v      = 1'b0;
`endif
        if (state == S_MUL) begin
            fin_fire   = last_iter;
            fin_res    = acc_nxt[DATA_W-1:0];
            fin_we_res = 1'b1;
            fin_sf     = set_flags_q;
`ifdef EXEC_FLAG_OVF_EN
            fin_c      = |acc_nxt[ACC_W-1:DATA_W];
            fin_v      = |acc_nxt[ACC_W-1:DATA_W];
`endif
        end else if (state == S_IDLE && start && op_in != OP_MUL) begin
            fin_fire   = 1'b1;
            fin_res    = alu_res;
            fin_we_res = (op_in != OP_CMP);
            fin_sf     = set_flags;
`ifdef EXEC_FLAG_OVF_EN
            fin_c      = alu_c;
            fin_v      = alu_v;
`endif
        end
    end

    // Control FSM, multiply datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            set_flags_q <= 1'b0;
            a_sh        <= '0;
            b_sh        <= '0;
            acc         <= '0;
            cnt         <= '0;
            result      <= '0;
            N_in        <= 1'b0;
            Z_in        <= 1'b0;
            WE_flags    <= 1'b0;
            WE_result   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef EXEC_FLAG_OVF_EN
            C_out       <= 1'b0;
            V_out       <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            WE_flags  <= 1'b0;
            WE_result <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        set_flags_q <= set_flags;
                        a_sh        <= ACC_W'(a);
                        b_sh        <= b;
                        acc         <= '0;
                        cnt         <= '0;
                        state       <= (op_in == OP_MUL) ? S_MUL : S_DONE;
                    end
                end
                S_MUL: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (last_iter) state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (fin_fire) begin
                result    <= fin_res;
                done      <= 1'b1;
                WE_result <= fin_we_res;
                WE_flags  <= fin_sf;
                if (fin_sf) begin
                    N_in  <= fin_res[MSB];
                    Z_in  <= (fin_res == '0);
`ifdef EXEC_FLAG_OVF_EN
                    C_out <= fin_c;
                    V_out <= fin_v;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_flag_unit.sv
// tb_exec_flag_unit: directed vectors with hand-computed expectations for
// exec_flag_unit (DATA_W=32). C_out/V_out checks compile in only when
// EXEC_FLAG_OVF_EN is defined.
module tb_exec_flag_unit;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic        set_flags;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        N_in;
    logic        Z_in;
    logic        WE_flags;
    logic        WE_result;
    logic        busy;
    logic        done;
`ifdef EXEC_FLAG_OVF_EN
    logic        C_out;
    logic        V_out;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int n_done;

    exec_flag_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .set_flags (set_flags),
        .a         (a),
        .b         (b),
        .result    (result),
        .N_in      (N_in),
        .Z_in      (Z_in),
        .WE_flags  (WE_flags),
        .WE_result (WE_result),
        .busy      (busy),
        .done      (done)
`ifdef EXEC_FLAG_OVF_EN
        ,
        .C_out     (C_out),
        .V_out     (V_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait (bounded) for done; lat = start-to-done cycles, -1 on timeout.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic sf, input bit inject, output int l);
        start = 1'b1; op = o; a = x; b = y; set_flags = sf;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom;
        l = -1;
        for (int i = 1; i <= 100; i++) begin
            if (done) begin
                l = i;
                break;
            end
            start = inject && (i == 2 || i == 10);
            op = OP_ADD;
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = OP_ADD; set_flags = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_flags", {30'b0, N_in, Z_in}, 32'h0);
        check("rst_pulses", {29'b0, WE_flags, WE_result, done}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // add wraps to zero
        run_op(OP_ADD, 32'd5, 32'hFFFF_FFFB, 1'b1, 1'b0, lat);
        check("add_lat", lat, 32'd1);
        check("add_res", result, 32'h0);
        check("add_NZ", {30'b0, N_in, Z_in}, 32'b01);
        check("add_we", {30'b0, WE_flags, WE_result}, 32'b11);
        check("add_busy_done", {31'b0, busy}, 32'h1);
        tick();
        check("add_done_pulse", {29'b0, done, WE_flags, WE_result}, 32'h0);
        check("add_busy_drop", {31'b0, busy}, 32'h0);
        check("add_hold", result, 32'h0);

        // cmp loads a-b but suppresses result write
        run_op(OP_CMP, 32'd3, 32'd7, 1'b1, 1'b0, lat);
        check("cmp_lat", lat, 32'd1);
        check("cmp_res", result, 32'hFFFF_FFFC);
        check("cmp_NZ", {30'b0, N_in, Z_in}, 32'b10);
        check("cmp_we", {30'b0, WE_flags, WE_result}, 32'b10);
        tick();

        // sub without flag update holds N/Z
        run_op(OP_SUB, 32'd10, 32'd3, 1'b0, 1'b0, lat);
        check("sub_res", result, 32'd7);
        check("sub_we", {30'b0, WE_flags, WE_result}, 32'b01);
        check("sub_NZ_hold", {30'b0, N_in, Z_in}, 32'b10);
        tick();

        // mul with ignored mid-flight starts
        run_op(OP_MUL, 32'd1000, 32'd3000, 1'b0, 1'b1, lat);
        check("mul_lat", lat, 32'd33);
        check("mul_res", result, 32'd3000000);
        check("mul_we", {30'b0, WE_flags, WE_result}, 32'b01);
        check("mul_NZ_hold", {30'b0, N_in, Z_in}, 32'b10);
        n_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) n_done++;
        end
        check("mul_single_done", n_done, 32'd0);
        check("mul_ignored_res", result, 32'd3000000);

        run_op(OP_ADD, 32'd1, 32'd2, 1'b1, 1'b0, lat);
        check("after_mul_lat", lat, 32'd1);
        check("after_mul_res", result, 32'd3);
        check("after_mul_NZ", {30'b0, N_in, Z_in}, 32'b00);
        tick();

        // truncated product
        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, lat);
        check("mul_trunc_lat", lat, 32'd33);
        check("mul_trunc_res", result, 32'h0);
        check("mul_trunc_NZ", {30'b0, N_in, Z_in}, 32'b01);
`ifdef EXEC_FLAG_OVF_EN
        check("mul_trunc_CV", {30'b0, C_out, V_out}, 32'b11);
`endif
        tick();

        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, lat);
        check("mul_ff_res", result, 32'h1);
        check("mul_ff_NZ", {30'b0, N_in, Z_in}, 32'b00);
        tick();

        // b=0 still takes the full iteration count
        run_op(OP_MUL, 32'd12345, 32'd0, 1'b1, 1'b0, lat);
        check("mul_b0_lat", lat, 32'd33);
        check("mul_b0_res", result, 32'h0);
        check("mul_b0_NZ", {30'b0, N_in, Z_in}, 32'b01);
`ifdef EXEC_FLAG_OVF_EN
        check("mul_b0_CV", {30'b0, C_out, V_out}, 32'b00);
`endif
        tick();

        run_op(OP_SUB, 32'd5, 32'd5, 1'b1, 1'b0, lat);
        check("sub_eq_res", result, 32'h0);
`ifdef EXEC_FLAG_OVF_EN
        check("sub_eq_CV", {30'b0, C_out, V_out}, 32'b10);
`endif
        tick();

        run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, lat);
        check("add_ovf_res", result, 32'h8000_0000);
        check("add_ovf_NZ", {30'b0, N_in, Z_in}, 32'b10);
`ifdef EXEC_FLAG_OVF_EN
        check("add_ovf_CV", {30'b0, C_out, V_out}, 32'b01);
`endif
        tick();

        run_op(OP_SUB, 32'd0, 32'd1, 1'b1, 1'b0, lat);
        check("sub_borrow_res", result, 32'hFFFF_FFFF);
`ifdef EXEC_FLAG_OVF_EN
        check("sub_borrow_CV", {30'b0, C_out, V_out}, 32'b00);
`endif
        tick();

        // asynchronous reset in the middle of a multiply
        start = 1'b1; op = OP_MUL; a = 32'd77; b = 32'd99; set_flags = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_result", result, 32'h0);
        check("midrst_flags", {30'b0, N_in, Z_in}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) n_done++;
        end
        check("midrst_no_done", n_done, 32'd0);

        run_op(OP_ADD, 32'd2, 32'd3, 1'b1, 1'b0, lat);
        check("post_rst_lat", lat, 32'd1);
        check("post_rst_res", result, 32'd5);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
